dp_ram_clr: RTL and testbench
=============================

DP_RAM_CLR -- requirements
Module: dp_ram_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; integer multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH words.
REQ-003 SHALL have parameter RD_MODE, default 0; 0 = read-first, 1 = write-first on A-write/B-read collision.
REQ-004 SHALL have parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written by the clear engine.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset_, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port a_addr, input, ADDR_WIDTH, port A address.
REQ-009 SHALL have port a_data, input, DATA_WIDTH, port A write data.
REQ-010 SHALL have port a_be, input, DATA_WIDTH/8, port A byte enables; bit i covers data[8i+7:8i].
REQ-011 SHALL have port a_we_, input, 1, port A write strobe, active low.
REQ-012 SHALL have port a_re, input, 1, port A read request, active high.
REQ-013 SHALL have port a_q / a_valid, output, DATA_WIDTH / 1, port A read data and qualifier.
REQ-014 SHALL have port b_addr / b_re, input, ADDR_WIDTH / 1, port B read address and request.
REQ-015 SHALL have port b_q / b_valid, output, DATA_WIDTH / 1, port B read data and qualifier.
REQ-016 SHALL have port clr_start, input, 1, clear request pulse.
REQ-017 SHALL have ports clr_busy / clr_done, output, 1 each, clear in progress / one-cycle completion pulse.

Function
REQ-018 SHALL write, when a_we_=0 and clr_busy=0, only the bytes of mem[a_addr] whose a_be bit is 1; a_be=0 leaves the word unchanged.
REQ-019 SHALL, when a_we_=1 and a_re=1, register mem[a_addr] to a_q with a_valid=1 one cycle later; a_we_=0 with a_re=1 performs no read.
REQ-020 SHALL, when b_re=1, register mem[b_addr] to b_q with b_valid=1 one cycle later, independent of port A.
REQ-021 SHALL hold a_q/b_q at their last value and drive a_valid/b_valid=0 in cycles with no read.
REQ-022 SHALL, on b_re=1 with b_addr equal to an accepted A write address in the same cycle, return the old word if RD_MODE=0, or the merged word (enabled bytes new, others old) if RD_MODE=1.
REQ-023 SHALL implement clear FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on clr_start=1.
REQ-024 SHALL in CLEAR write CLEAR_VALUE to address counter 0,1,..,RAM_DEPTH-1, one word per cycle, with clr_busy=1; after address RAM_DEPTH-1 go to DONE.
REQ-025 SHALL in DONE drive clr_done=1 for exactly one cycle, clr_busy=0, then return to IDLE; total clear takes RAM_DEPTH+1 cycles.
REQ-026 SHALL ignore clr_start while in CLEAR or DONE, and drop port A writes while clr_busy=1.
REQ-027 SHALL service reads on both ports during CLEAR; same-address collision with the clear write follows RD_MODE as in REQ-022.

Reset
REQ-028 SHALL on reset_=0 immediately drive a_q=0, b_q=0, a_valid=0, b_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, counter=0.
REQ-029 SHALL NOT initialise memory contents on reset; reset during CLEAR aborts the sweep, leaving higher addresses unchanged.

Configuration
REQ-030 SHALL, with macro DP_RAM_OUTREG_EN defined, add one output register stage on both ports: read latency 2, a_valid/b_valid delayed to match, stage reset to 0.
REQ-031 SHALL, without DP_RAM_OUTREG_EN, have read latency 1 on both ports as in REQ-019/REQ-020.

Verification
REQ-032 SHALL pass: write 0xDEADBEEF to addr 5 with a_be=4'hF, then a_re at addr 5 -> a_q=0xDEADBEEF, a_valid=1 one cycle later (two with DP_RAM_OUTREG_EN).
REQ-033 SHALL pass: addr 5=0xDEADBEEF, write 0x11223344 with a_be=4'b0101 -> read gives 0xDE22BE44.
REQ-034 SHALL pass: addr 9=0xAAAAAAAA, same cycle write 0x55555555 addr 9 and b_re addr 9 -> b_q=0xAAAAAAAA (RD_MODE=0), 0x55555555 (RD_MODE=1).
REQ-035 SHALL pass: clr_start with ADDR_WIDTH=4 -> clr_busy high 16 cycles, clr_done pulse on cycle 17, all 16 words read CLEAR_VALUE; a_we_=0 during busy has no effect.
REQ-036 SHALL pass: reset_ low at counter=8 of clear -> outputs 0 immediately, addr 0-7 = CLEAR_VALUE, addr 8-15 unchanged.

Source files
------------

// File: rtl/dp_ram_clr.sv
// dp_ram_clr: dual-port RAM (port A read/write with byte enables, port B read-only) plus a full-array clear engine.
// Macro DP_RAM_OUTREG_EN adds one output register stage on both read ports (read latency 2 instead of 1).
module dp_ram_clr #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 8,
   parameter int unsigned           RD_MODE     = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clock,
   input  logic                    reset_,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic                    a_we_,
   input  logic                    a_re,
   output logic [DATA_WIDTH-1:0]   a_q,
   output logic                    a_valid,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic                    b_re,
   output logic [DATA_WIDTH-1:0]   b_q,
   output logic                    b_valid,
   input  logic                    clr_start,
   output logic                    clr_busy,
   output logic                    clr_done
);

   localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} clr_state_t;

   clr_state_t              state, state_nxt;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic                    clr_busy_nxt, clr_done_nxt;

   logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [NUM_BYTES-1:0]    wr_be;
   logic                    a_rd;
   logic [DATA_WIDTH-1:0]   a_rd_word, b_rd_word;

   logic [DATA_WIDTH-1:0]   a_q1, b_q1;
   logic                    a_valid1, b_valid1;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [NUM_BYTES-1:0]  be);
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < int'(NUM_BYTES); i++)
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      return res;
   endfunction

   // Clear FSM state, sweep counter and registered status flags
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_cnt  <= (state == CLEAR) ? clr_cnt + ADDR_WIDTH'(1) : '0;
         clr_busy <= clr_busy_nxt;
         clr_done <= clr_done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_start) state_nxt = CLEAR;
         CLEAR:   if (clr_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The clear sweep owns the write port; port A writes are dropped while it runs
   always_comb begin
      wr_en        = 1'b0;
      wr_addr      = a_addr;
      wr_data      = a_data;
      wr_be        = a_be;
      a_rd         = a_re & a_we_;
      clr_busy_nxt = (state_nxt == CLEAR);
      clr_done_nxt = (state_nxt == DONE);
      if (state == CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt;
         wr_data = CLEAR_VALUE;
         wr_be   = '1;
      end else if (!a_we_) begin
         wr_en   = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         for (int i = 0; i < int'(NUM_BYTES); i++)
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
   end

   // Write-first mode forwards the merged word on a same-address collision
   always_comb begin
      a_rd_word = mem[a_addr];
      b_rd_word = mem[b_addr];
      if (RD_MODE != 0 && wr_en) begin
         if (wr_addr == a_addr) a_rd_word = merge_bytes(a_rd_word, wr_data, wr_be);
         if (wr_addr == b_addr) b_rd_word = merge_bytes(b_rd_word, wr_data, wr_be);
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         a_q1     <= '0;
         a_valid1 <= 1'b0;
         b_q1     <= '0;
         b_valid1 <= 1'b0;
      end else begin
         a_valid1 <= a_rd;
         b_valid1 <= b_re;
         if (a_rd) a_q1 <= a_rd_word;
         if (b_re) b_q1 <= b_rd_word;
      end
   end

`ifdef DP_RAM_OUTREG_EN
   logic [DATA_WIDTH-1:0] a_q2, b_q2;
   logic                  a_valid2, b_valid2;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         a_q2     <= '0;
         a_valid2 <= 1'b0;
         b_q2     <= '0;
         b_valid2 <= 1'b0;
      end else begin
         a_valid2 <= a_valid1;
         b_valid2 <= b_valid1;
         if (a_valid1) a_q2 <= a_q1;
         if (b_valid1) b_q2 <= b_q1;
      end
   end

   assign a_q     = a_q2;
   assign a_valid = a_valid2;
   assign b_q     = b_q2;
   assign b_valid = b_valid2;
`else
   assign a_q     = a_q1;
   assign a_valid = a_valid1;
   assign b_q     = b_q1;
   assign b_valid = b_valid1;
`endif

endmodule

// File: tb/tb_dp_ram_clr.sv
// tb_dp_ram_clr: randomized bench for dp_ram_clr, read-first and write-first instances side by side,
// checked each cycle against a behavioural memory model. Honours DP_RAM_OUTREG_EN for read latency.
module tb_dp_ram_clr;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam logic [31:0] CLR = 32'hC1EA_5A00;
`ifdef DP_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clock, reset_;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data;
   logic [3:0]    a_be;
   logic          a_we_, a_re, b_re, clr_start;

   logic [DW-1:0] a_q0, b_q0, a_q1, b_q1;
   logic          a_v0, b_v0, a_v1, b_v1;
   logic          busy0, done0, busy1, done1;

   dp_ram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_MODE(0), .CLEAR_VALUE(CLR)) dut0 (
      .clock(clock), .reset_(reset_), .a_addr(a_addr), .a_data(a_data), .a_be(a_be),
      .a_we_(a_we_), .a_re(a_re), .a_q(a_q0), .a_valid(a_v0), .b_addr(b_addr), .b_re(b_re),
      .b_q(b_q0), .b_valid(b_v0), .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0));

   dp_ram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_MODE(1), .CLEAR_VALUE(CLR)) dut1 (
      .clock(clock), .reset_(reset_), .a_addr(a_addr), .a_data(a_data), .a_be(a_be),
      .a_we_(a_we_), .a_re(a_re), .a_q(a_q1), .a_valid(a_v1), .b_addr(b_addr), .b_re(b_re),
      .b_q(b_q1), .b_valid(b_v1), .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: memory array, clear position (-1 idle, 0..DEPTH-1 sweeping, DEPTH done), read pipes
   logic [31:0] mem_m [DEPTH];
   int          clr_pos;
   logic        pa_v [2], pb_v [2];
   logic [31:0] pa_d0 [2], pa_d1 [2], pb_d0 [2], pb_d1 [2];
   logic        ea_v, eb_v;
   logic [31:0] ea_q0, ea_q1, eb_q0, eb_q1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      clr_pos = -1;
      for (int i = 0; i < 2; i++) begin
         pa_v[i] = 0; pb_v[i] = 0;
         pa_d0[i] = 0; pa_d1[i] = 0; pb_d0[i] = 0; pb_d1[i] = 0;
      end
      ea_v = 0; eb_v = 0; ea_q0 = 0; ea_q1 = 0; eb_q0 = 0; eb_q1 = 0;
   endtask

   task automatic model_edge();
      logic        wen, a_rd;
      logic [3:0]  waddr, wbe;
      logic [31:0] wdata, nw, old_a, old_b;
      if (!reset_) return;
      wen = 0; waddr = 0; wdata = 0; wbe = 0;
      if (clr_pos >= 0 && clr_pos < DEPTH) begin
         wen = 1; waddr = 4'(clr_pos); wdata = CLR; wbe = 4'hF;
      end else if (!a_we_) begin
         wen = 1; waddr = a_addr; wdata = a_data; wbe = a_be;
      end
      nw    = merge(mem_m[waddr], wdata, wbe);
      old_a = mem_m[a_addr];
      old_b = mem_m[b_addr];
      a_rd  = a_re && a_we_;
      pa_v[1] = pa_v[0]; pa_d0[1] = pa_d0[0]; pa_d1[1] = pa_d1[0];
      pb_v[1] = pb_v[0]; pb_d0[1] = pb_d0[0]; pb_d1[1] = pb_d1[0];
      pa_v[0] = a_rd; pb_v[0] = b_re;
      pa_d0[0] = old_a; pa_d1[0] = (wen && waddr == a_addr) ? nw : old_a;
      pb_d0[0] = old_b; pb_d1[0] = (wen && waddr == b_addr) ? nw : old_b;
      if (wen) mem_m[waddr] = nw;
      if (clr_pos == -1) begin
         if (clr_start) clr_pos = 0;
      end else if (clr_pos == DEPTH) clr_pos = -1;
      else clr_pos++;
      ea_v = pa_v[LAT-1];
      eb_v = pb_v[LAT-1];
      if (ea_v) begin ea_q0 = pa_d0[LAT-1]; ea_q1 = pa_d1[LAT-1]; end
      if (eb_v) begin eb_q0 = pb_d0[LAT-1]; eb_q1 = pb_d1[LAT-1]; end
   endtask

   task automatic compare_all();
      logic eb, ed;
      eb = (clr_pos >= 0 && clr_pos < DEPTH);
      ed = (clr_pos == DEPTH);
      check("a_q_rf",  a_q0, ea_q0);           check("a_q_wf",  a_q1, ea_q1);
      check("a_v_rf",  32'(a_v0), 32'(ea_v));  check("a_v_wf",  32'(a_v1), 32'(ea_v));
      check("b_q_rf",  b_q0, eb_q0);           check("b_q_wf",  b_q1, eb_q1);
      check("b_v_rf",  32'(b_v0), 32'(eb_v));  check("b_v_wf",  32'(b_v1), 32'(eb_v));
      check("busy_rf", 32'(busy0), 32'(eb));   check("busy_wf", 32'(busy1), 32'(eb));
      check("done_rf", 32'(done0), 32'(ed));   check("done_wf", 32'(done1), 32'(ed));
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later, returns at the falling edge
   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      a_we_ = 1; a_re = 0; b_re = 0; clr_start = 0;
      a_addr = 0; b_addr = 0; a_data = 0; a_be = 0;
   endtask

   task automatic a_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
      a_we_ = 0; a_addr = addr; a_data = data; a_be = be;
      step();
      a_we_ = 1;
   endtask

   task automatic a_read(input logic [3:0] addr, output logic [31:0] q, output logic v);
      a_re = 1; a_addr = addr;
      step();
      a_re = 0;
      repeat (LAT - 1) step();
      q = a_q0; v = a_v0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_q"},  a_q0 | a_q1, 32'h0);
      check({tag, "_b_q"},  b_q0 | b_q1, 32'h0);
      check({tag, "_vld"},  32'({a_v0, a_v1, b_v0, b_v1}), 32'h0);
      check({tag, "_clr"},  32'({busy0, busy1, done0, done1}), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q;
      logic        v;
      int          n_busy, done_at;

      idle_inputs();
      reset_ = 1;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
      #2 reset_ = 0;
      model_reset();
      #1 check_reset_outputs("reset");
      @(negedge clock);
      @(negedge clock);
      reset_ = 1;

      // Full clear while hammering port A writes, which must all be dropped
      clr_start = 1;
      step();
      n_busy = int'(busy0);
      done_at = 0;
      a_we_ = 0;
      for (int i = 2; i <= 40 && done_at == 0; i++) begin
         a_addr = 4'($urandom); a_data = $urandom; a_be = 4'hF; clr_start = (i < 8);
         step();
         if (busy0) n_busy++;
         if (done0) done_at = i;
      end
      idle_inputs();
      check("clr_busy_cycles", 32'(n_busy), 32'd16);
      check("clr_done_cycle", 32'(done_at), 32'd17);
      for (int i = 0; i < DEPTH; i++) begin
         a_read(4'(i), q, v);
         check("clr_word", q, CLR);
      end

      // Full-word write then read back
      a_write(4'd5, 32'hDEADBEEF, 4'hF);
      a_read(4'd5, q, v);
      check("wr_rd_data", q, 32'hDEADBEEF);
      check("wr_rd_valid", 32'(v), 32'd1);

      // Partial byte-enable merge
      a_write(4'd5, 32'h11223344, 4'b0101);
      a_read(4'd5, q, v);
      check("be_merge", q, 32'hDE22BE44);

      // A write / B read collision, read-first vs write-first
      a_write(4'd9, 32'hAAAAAAAA, 4'hF);
      a_we_ = 0; a_addr = 4'd9; a_data = 32'h55555555; a_be = 4'hF;
      b_re = 1; b_addr = 4'd9;
      step();
      idle_inputs();
      repeat (LAT - 1) step();
      check("coll_read_first", b_q0, 32'hAAAAAAAA);
      check("coll_write_first", b_q1, 32'h55555555);

      // Randomized traffic with occasional clears
      for (int n = 0; n < 1500; n++) begin
         a_we_     = ($urandom_range(0, 1) == 0);
         a_re      = ($urandom_range(0, 1) == 0);
         b_re      = ($urandom_range(0, 1) == 0);
         a_addr    = 4'($urandom);
         b_addr    = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom);
         a_data    = $urandom;
         a_be      = 4'($urandom);
         clr_start = ($urandom_range(0, 59) == 0);
         step();
      end
      idle_inputs();
      repeat (20) step();

      // Reset in the middle of a sweep: lower half cleared, upper half untouched
      for (int i = 0; i < DEPTH; i++) a_write(4'(i), 32'h1000_0000 + 32'(i), 4'hF);
      clr_start = 1;
      step();
      clr_start = 0;
      repeat (8) step();
      reset_ = 0;
      model_reset();
      #1 check_reset_outputs("abort");
      @(negedge clock);
      reset_ = 1;
      for (int i = 0; i < DEPTH; i++) begin
         a_read(4'(i), q, v);
         check("abort_word", q, (i < 8) ? CLR : 32'h1000_0000 + 32'(i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
